tube_arbiter: RTL and testbench

Time-shares the 8-digit seven-segment display between up to NREQ producers, such as the CPU MMIO display register, a debug/PC monitor and a UART status source. Each producer offers a 32-bit value with a valid/ack handshake. The arbiter grants the display round-robin and holds each accepted value for a minimum dwell time so that it stays readable. Its registered `disp_data` output drives the `in` port of `tube_driver` directly. Requester 0 can optionally pre-empt a running dwell.

---
 rtl/tube_arbiter.sv | 88 ++++++++
 tb/tb_tube_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tube_arbiter.sv
// Round-robin arbiter that time-shares the seven-segment display between NREQ producers,
// holding each accepted word for a minimum dwell; requester 0 may optionally pre-empt.
module tube_arbiter #(
    parameter int                NREQ        = 4,
    parameter int                DATA_W      = 32,
    parameter int                HOLD_CYCLES = 4,
    parameter bit                PREEMPT0    = 1'b1,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    output logic [NREQ-1:0]           req_ack,
    output logic [DATA_W-1:0]         disp_data,
    output logic [$clog2(NREQ)-1:0]   disp_owner,
    output logic                      disp_busy
);
    localparam int OW = $clog2(NREQ);
    localparam int HW = $clog2(HOLD_CYCLES);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    logic [0:0]    state;
    logic [HW-1:0] hold_cnt;
    logic [OW-1:0] rr_ptr;

    logic          rr_found;
    logic [OW-1:0] rr_idx;
    logic [OW-1:0] scan_idx;
    logic          preempt;
    logic          accept;
    logic [OW-1:0] grant_idx;
    logic [OW-1:0] next_ptr;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = OW'((int'(rr_ptr) + k) % NREQ);
            if (!rr_found && req_valid[scan_idx]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        preempt   = PREEMPT0 && (state == SHOW) && (hold_cnt != '0) &&
                    req_valid[0] && (disp_owner != '0);
        accept    = preempt || (rr_found && (state == IDLE || hold_cnt == '0));
        grant_idx = preempt ? '0 : rr_idx;
        next_ptr  = OW'((int'(grant_idx) + 1) % NREQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            rr_ptr     <= '0;
            req_ack    <= '0;
            disp_data  <= RESET_VAL;
            disp_owner <= '0;
            disp_busy  <= 1'b0;
        end else begin
            req_ack <= '0;
            if (accept) begin
                // Only the granted slot is read, so junk on other slots never reaches the display.
                disp_data          <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
                disp_owner         <= grant_idx;
                req_ack[grant_idx] <= 1'b1;
                hold_cnt           <= HW'(HOLD_CYCLES - 1);
                rr_ptr             <= next_ptr;
                state              <= SHOW;
                disp_busy          <= 1'b1;
            end else if (state == SHOW && hold_cnt != '0) begin
                hold_cnt  <= hold_cnt - 1'b1;
                disp_busy <= (hold_cnt != HW'(1));
            end else begin
                state     <= IDLE;
                disp_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tube_arbiter.sv
// Directed bench for tube_arbiter: a per-cycle vector table plus hand sequences for
// round-robin, pre-emption, ack/valid overlap and reset mid-dwell.
module tb_tube_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   ack_p, ack_n;
    logic [31:0]  data_p, data_n;
    logic [1:0]   own_p, own_n;
    logic         busy_p, busy_n;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tube_arbiter #(.NREQ(4), .DATA_W(32), .HOLD_CYCLES(4), .PREEMPT0(1'b1), .RESET_VAL(32'h0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ack(ack_p), .disp_data(data_p), .disp_owner(own_p), .disp_busy(busy_p));

    tube_arbiter #(.NREQ(4), .DATA_W(32), .HOLD_CYCLES(4), .PREEMPT0(1'b0), .RESET_VAL(32'h0)) dut_np (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ack(ack_n), .disp_data(data_n), .disp_owner(own_n), .disp_busy(busy_n));

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  exp_ack;
        logic [31:0] exp_data;
        logic [1:0]  exp_owner;
        logic        exp_busy;
    } vec_t;

    vec_t tv[21];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [31:0] v);
        req_data[i*32 +: 32] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'b0000;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        tv[0]  = '{1'b1, 4'b1111, 4'b0000, 32'h00000000, 2'd0, 1'b0};
        tv[1]  = '{1'b1, 4'b1111, 4'b0000, 32'h00000000, 2'd0, 1'b0};
        tv[2]  = '{1'b0, 4'b1111, 4'b0001, 32'hA0000000, 2'd0, 1'b1};
        tv[3]  = '{1'b0, 4'b0000, 4'b0000, 32'hA0000000, 2'd0, 1'b1};
        tv[4]  = '{1'b0, 4'b0000, 4'b0000, 32'hA0000000, 2'd0, 1'b1};
        tv[5]  = '{1'b0, 4'b0000, 4'b0000, 32'hA0000000, 2'd0, 1'b0};
        tv[6]  = '{1'b0, 4'b0000, 4'b0000, 32'hA0000000, 2'd0, 1'b0};
        tv[7]  = '{1'b0, 4'b0100, 4'b0100, 32'h12345678, 2'd2, 1'b1};
        tv[8]  = '{1'b0, 4'b0000, 4'b0000, 32'h12345678, 2'd2, 1'b1};
        tv[9]  = '{1'b0, 4'b0000, 4'b0000, 32'h12345678, 2'd2, 1'b1};
        tv[10] = '{1'b0, 4'b0000, 4'b0000, 32'h12345678, 2'd2, 1'b0};
        tv[11] = '{1'b0, 4'b0000, 4'b0000, 32'h12345678, 2'd2, 1'b0};
        tv[12] = '{1'b0, 4'b1010, 4'b1000, 32'hD0000000, 2'd3, 1'b1};
        tv[13] = '{1'b0, 4'b0010, 4'b0000, 32'hD0000000, 2'd3, 1'b1};
        tv[14] = '{1'b0, 4'b0010, 4'b0000, 32'hD0000000, 2'd3, 1'b1};
        tv[15] = '{1'b0, 4'b0010, 4'b0000, 32'hD0000000, 2'd3, 1'b0};
        tv[16] = '{1'b0, 4'b0010, 4'b0010, 32'hB0000000, 2'd1, 1'b1};
        tv[17] = '{1'b0, 4'b0000, 4'b0000, 32'hB0000000, 2'd1, 1'b1};
        tv[18] = '{1'b0, 4'b0000, 4'b0000, 32'hB0000000, 2'd1, 1'b1};
        tv[19] = '{1'b0, 4'b0000, 4'b0000, 32'hB0000000, 2'd1, 1'b0};
        tv[20] = '{1'b0, 4'b0000, 4'b0000, 32'hB0000000, 2'd1, 1'b0};

        rst = 1'b1;
        req_valid = 4'b0000;
        req_data = '0;
        set_slot(0, 32'hA0000000);
        set_slot(1, 32'hB0000000);
        set_slot(2, 32'h12345678);
        set_slot(3, 32'hD0000000);
        #2;

        // Table: reset, first grant, single requester, idle retention, wrap from rr_ptr=3
        for (int i = 0; i < 21; i++) begin
            rst = tv[i].rst;
            req_valid = tv[i].valid;
            step();
            check($sformatf("tv%0d ack", i),   32'(ack_p),  32'(tv[i].exp_ack));
            check($sformatf("tv%0d data", i),  data_p,      tv[i].exp_data);
            check($sformatf("tv%0d owner", i), 32'(own_p),  32'(tv[i].exp_owner));
            check($sformatf("tv%0d busy", i),  32'(busy_p), 32'(tv[i].exp_busy));
            check($sformatf("tv%0d np_ack", i), 32'(ack_n), 32'(tv[i].exp_ack));
        end

        // Round-robin under continuous demand, no pre-emption: one grant every 4 cycles
        do_reset();
        set_slot(0, 32'hA0000000);
        set_slot(1, 32'hB0000000);
        set_slot(2, 32'hC0000000);
        set_slot(3, 32'hD0000000);
        req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            logic [3:0]  ea;
            logic [31:0] ed;
            step();
            ea = (c % 4 == 0) ? (4'b0001 << ((c / 4) % 4)) : 4'b0000;
            ed = {4'hA + 4'((c / 4) % 4), 28'h0};
            check($sformatf("rr c%0d ack", c), 32'(ack_n), 32'(ea));
            check($sformatf("rr c%0d data", c), data_n, ed);
            if (ea != 4'b0000)
                check($sformatf("rr c%0d owner", c), 32'(own_n), (c / 4) % 4);
        end

        // Ack/valid overlap: requester 1 held valid, one ack per dwell, re-grant only when alone
        do_reset();
        set_slot(1, 32'hDDDDAAAA);
        set_slot(2, 32'hC0000000);
        req_valid = 4'b0010;
        for (int c = 0; c < 9; c++) begin
            logic [3:0] ea;
            if (c == 7) req_valid = 4'b0110;
            step();
            ea = (c == 0 || c == 4) ? 4'b0010 : (c == 8) ? 4'b0100 : 4'b0000;
            check($sformatf("ovl c%0d ack", c), 32'(ack_p), 32'(ea));
        end
        check("ovl data", data_p, 32'hC0000000);

        // Pre-emption by requester 0 one cycle into owner 3's dwell
        do_reset();
        set_slot(3, 32'h98765432);
        set_slot(0, 32'h38273625);
        req_valid = 4'b1000;
        step();
        check("pre e0 owner", 32'(own_p), 32'd3);
        check("pre e0 data", data_p, 32'h98765432);
        req_valid = 4'b0001;
        step();
        check("pre e1 ack", 32'(ack_p), 32'b0001);
        check("pre e1 owner", 32'(own_p), 32'd0);
        check("pre e1 data", data_p, 32'h38273625);
        check("pre e1 busy", 32'(busy_p), 32'd1);
        check("np e1 ack", 32'(ack_n), 32'd0);
        check("np e1 data", data_n, 32'h98765432);
        step();
        step();
        check("np e3 busy", 32'(busy_n), 32'd0);
        check("pre e3 busy", 32'(busy_p), 32'd1);
        step();
        check("np e4 ack", 32'(ack_n), 32'b0001);
        check("np e4 data", data_n, 32'h38273625);
        check("pre e4 busy", 32'(busy_p), 32'd0);
        check("pre e4 ack", 32'(ack_p), 32'd0);

        // Reset mid-dwell with hold_cnt = 2
        do_reset();
        set_slot(2, 32'h92736453);
        req_valid = 4'b0100;
        step();
        check("rmd e0 owner", 32'(own_p), 32'd2);
        req_valid = 4'b0000;
        step();
        rst = 1'b1;
        req_valid = 4'b0100;
        step();
        check("rmd data", data_p, 32'h0);
        check("rmd busy", 32'(busy_p), 32'd0);
        check("rmd ack", 32'(ack_p), 32'd0);
        check("rmd owner", 32'(own_p), 32'd0);
        rst = 1'b0;
        step();
        check("rmd regrant ack", 32'(ack_p), 32'b0100);
        check("rmd regrant data", data_p, 32'h92736453);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
